pim_result_fifo: RTL

Parametrised multi-entry result buffer between the PIM macro's ADC outputs and the RISC-V peripheral read path. It is the successor to the single-line output buffer. It captures whole PIM output lines into a DEPTH-entry FIFO, so several parallel or row-by-row reads can complete before software drains them. Software drains lines as WORD_W-bit words with an auto-incrementing word pointer. Overflow, underflow and fill level are reported to the peripheral controller.

---
 rtl/pim_result_fifo.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pim_result_fifo.sv
// Multi-entry PIM output-line buffer drained by software as WORD_W-bit words, LSW first.
// Latency: read data 1 cycle after rd_req_i; a captured line is readable from the next cycle.
// Backpressure: none; a capture when full is dropped (sticky overflow), a read when empty returns 0 (sticky underflow).
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   output_i, capture_i        PIM output line and its one-cycle store pulse
//   rd_req_i                   one-cycle pulse requesting the next word of the head line
//   clear_i                    synchronous flush of pointers, level and sticky flags
//   rd_data_o, rd_valid_o      registered read word and its one-cycle qualifier
//   empty_o, full_o, level_o   fill status derived from the registered level counter
//   word_idx_o                 next word to be read within the head line
//   overflow_o, underflow_o    sticky error flags
module pim_result_fifo #(
    parameter int OUT_W  = 1024,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4,
    localparam int WPL   = OUT_W / WORD_W,
    localparam int LW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH),
    localparam int WIW   = (WPL > 1) ? $clog2(WPL) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [OUT_W-1:0]  output_i,
    input  logic              capture_i,
    input  logic              rd_req_i,
    input  logic              clear_i,
    output logic [WORD_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [LW-1:0]     level_o,
    output logic [WIW-1:0]    word_idx_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [WIW-1:0] LAST_WORD = WIW'(WPL - 1);
    localparam logic [LW-1:0]  FULL_LVL  = LW'(DEPTH);

    // Line storage carries no reset; only control state is reset.
    logic [OUT_W-1:0]  r_mem [DEPTH];

    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [LW-1:0]     r_level;
    logic [WIW-1:0]    r_widx;
    logic              r_ovf;
    logic              r_udf;
    logic              r_rd_valid;
    logic [WORD_W-1:0] r_rd_data;

    logic              w_empty;
    logic              w_full;
    logic              w_rd_ok;
    logic              w_pop;
    logic              w_cap_ok;
    logic [OUT_W-1:0]  w_head_line;
    logic [WORD_W-1:0] w_head_word;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == FULL_LVL);
    assign w_rd_ok     = rd_req_i && !w_empty && !clear_i;
    // The final word of the head line frees its entry this cycle.
    assign w_pop       = w_rd_ok && (r_widx == LAST_WORD);
    // When full, wp == rp: the incoming line overwrites the head entry
    // in the same edge that reads out its last word, which is safe.
    assign w_cap_ok    = capture_i && !clear_i && (!w_full || w_pop);
    assign w_head_line = r_mem[r_rp];
    assign w_head_word = w_head_line[r_widx*WORD_W +: WORD_W];

    always_ff @(posedge clk_i) begin
        if (w_cap_ok) begin
            r_mem[r_wp] <= output_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_level    <= '0;
            r_widx     <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else if (clear_i) begin
            // Flush control state; rd_data holds since rd_valid drops.
            r_wp       <= '0;
            r_rp       <= '0;
            r_level    <= '0;
            r_widx     <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_req_i;
            if (rd_req_i) begin
                r_rd_data <= w_rd_ok ? w_head_word : '0;
            end
            if (rd_req_i && w_empty) begin
                r_udf <= 1'b1;
            end
            if (capture_i && !w_cap_ok) begin
                r_ovf <= 1'b1;
            end
            if (w_cap_ok) begin
                r_wp <= r_wp + PW'(1);
            end
            if (w_rd_ok) begin
                r_widx <= w_pop ? '0 : r_widx + WIW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PW'(1);
            end
            case ({w_cap_ok, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign rd_data_o   = r_rd_data;
    assign rd_valid_o  = r_rd_valid;
    assign empty_o     = w_empty;
    assign full_o      = w_full;
    assign level_o     = r_level;
    assign word_idx_o  = r_widx;
    assign overflow_o  = r_ovf;
    assign underflow_o = r_udf;

endmodule
